// File: rtl/nibble_link_pkg.sv
// rtl/nibble_link_pkg.sv - frame layout helpers and FSM states shared by both ends of the nibble link
package nibble_link_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECEIVE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  function automatic int num_units(input int data_width, input int unit_width);
    return data_width / unit_width;
  endfunction

  function automatic int has_rem(input int data_width, input int unit_width);
    return num_units(data_width, unit_width) % 2;
  endfunction

  // Odd unit counts spend one extra byte whose low nibble is padding.
  function automatic int num_rx(input int data_width, input int unit_width);
    return num_units(data_width, unit_width) / 2 + has_rem(data_width, unit_width);
  endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// rtl/rx_gap_timer.sv - saturating idle-gap counter that flags the last allowed idle clock
module rx_gap_timer #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, clear, tick};
    assign expire = 1'b0;
  end else begin : g_on
    localparam int W = ($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
      if (rst || clear) begin
        count <= '0;
      end else if (tick && (count != '1)) begin
        count <= count + 1'b1;
      end
    end

    assign expire = (count == LAST);
  end

endmodule

// File: rtl/nibble_unpacker_deserializer.sv
// rtl/nibble_unpacker_deserializer.sv - reassembles nibble-packed UART bytes into one atomic frame vector
module nibble_unpacker_deserializer
  import nibble_link_pkg::*;
#(
  parameter int DATA_WIDTH     = 324,
  parameter int UNIT_WIDTH     = 4,
  parameter int CHUNK_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_reception,
  input  logic [CHUNK_WIDTH-1:0] uart_rx_data,
  input  logic                   uart_rx_valid,
  output logic                   uart_rx_ready,
  output logic [DATA_WIDTH-1:0]  data_received,
  output logic                   reception_done,
  output logic                   pad_error,
  output logic                   rx_timeout
);

  localparam int NUM_UNITS = num_units(DATA_WIDTH, UNIT_WIDTH);
  localparam int HAS_REM   = has_rem(DATA_WIDTH, UNIT_WIDTH);
  localparam int NUM_RX    = num_rx(DATA_WIDTH, UNIT_WIDTH);
  localparam int CNT_W     = (NUM_RX > 1) ? $clog2(NUM_RX) : 1;
  localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(NUM_RX - 1);

  state_t                state, state_next;
  logic [CNT_W-1:0]      rx_counter;
  logic [DATA_WIDTH-1:0] shadow, shadow_next;
  logic                  accept, last_byte, arm, gap_expire, timeout_hit;

  assign uart_rx_ready = (state == S_RECEIVE);
  assign accept        = uart_rx_valid && uart_rx_ready;
  assign last_byte     = accept && (rx_counter == LAST_RX);
  assign arm           = (state == S_IDLE) && start_reception;
  assign timeout_hit   = (state == S_RECEIVE) && !accept && gap_expire;

  rx_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (arm || accept),
    .tick  ((state == S_RECEIVE) && !accept),
    .expire(gap_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start_reception) state_next = S_RECEIVE;
      S_RECEIVE: begin
        if (last_byte) begin
          state_next = S_DONE;
        end else if (timeout_hit) begin
          state_next = S_IDLE;
        end
      end
      S_DONE:    if (!start_reception) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Byte k carries units 2k (high nibble) and 2k+1; a pad nibble past the last unit is never stored.
  always_comb begin
    shadow_next = shadow;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (accept && (int'(rx_counter) == i / 2)) begin
        if (i % 2 == 0) begin
          shadow_next[DATA_WIDTH-1-i*UNIT_WIDTH -: UNIT_WIDTH] = uart_rx_data[CHUNK_WIDTH-1 -: UNIT_WIDTH];
        end else begin
          shadow_next[DATA_WIDTH-1-i*UNIT_WIDTH -: UNIT_WIDTH] = uart_rx_data[UNIT_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_counter     <= '0;
      shadow         <= '0;
      data_received  <= '0;
      reception_done <= 1'b0;
      pad_error      <= 1'b0;
      rx_timeout     <= 1'b0;
    end else begin
      if (arm) begin
        rx_counter     <= '0;
        shadow         <= '0;
        reception_done <= 1'b0;
        pad_error      <= 1'b0;
        rx_timeout     <= 1'b0;
      end
      if (accept) begin
        shadow     <= shadow_next;
        rx_counter <= rx_counter + 1'b1;
      end
      if (last_byte) begin
        data_received  <= shadow_next;
        reception_done <= 1'b1;
        pad_error      <= (HAS_REM != 0) && (uart_rx_data[UNIT_WIDTH-1:0] != '0);
      end
      if (timeout_hit) begin
        rx_timeout <= 1'b1;
        shadow     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nibble_unpacker_deserializer.sv
// tb/tb_nibble_unpacker_deserializer.sv - scoreboard bench with a unit-list reference model
module tb_nibble_unpacker_deserializer;

  localparam int DW_A = 324;
  localparam int DW_B = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            start_a, valid_a, ready_a, done_a, pad_a, to_a;
  logic [7:0]      data_a;
  logic [DW_A-1:0] out_a;
  logic            start_b, valid_b, ready_b, done_b, pad_b, to_b;
  logic [7:0]      data_b;
  logic [DW_B-1:0] out_b;

  nibble_unpacker_deserializer #(
    .DATA_WIDTH(DW_A), .UNIT_WIDTH(4), .CHUNK_WIDTH(8), .TIMEOUT_CYCLES(16)
  ) dut_a (
    .clk(clk), .rst(rst), .start_reception(start_a), .uart_rx_data(data_a),
    .uart_rx_valid(valid_a), .uart_rx_ready(ready_a), .data_received(out_a),
    .reception_done(done_a), .pad_error(pad_a), .rx_timeout(to_a)
  );

  nibble_unpacker_deserializer #(
    .DATA_WIDTH(DW_B), .UNIT_WIDTH(4), .CHUNK_WIDTH(8), .TIMEOUT_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst(rst), .start_reception(start_b), .uart_rx_data(data_b),
    .uart_rx_valid(valid_b), .uart_rx_ready(ready_b), .data_received(out_b),
    .reception_done(done_b), .pad_error(pad_b), .rx_timeout(to_b)
  );

  typedef struct {
    bit           is_to;
    logic [323:0] data;
    bit           pad;
  } exp_t;

  exp_t         q_a[$];
  exp_t         q_b[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  int           n_push_a = 0, n_push_b = 0, n_ev_a = 0, n_ev_b = 0;
  logic [7:0]   fb[41];
  logic [323:0] last_a = '0;

  task automatic chk(input string name, input logic [323:0] act, input logic [323:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Frame = ordered list of units; byte k holds units 2k and 2k+1, unit 0 ends up most significant.
  function automatic logic [323:0] model_vec(input int nunits);
    logic [323:0] v;
    logic [7:0]   b;
    v = '0;
    for (int i = 0; i < nunits; i++) begin
      b = fb[i / 2];
      v = (v << 4) | 324'((i % 2 == 0) ? b[7:4] : b[3:0]);
    end
    return v;
  endfunction

  task automatic push_done_a();
    exp_t e;
    e.is_to = 1'b0;
    e.data  = model_vec(81);
    e.pad   = (fb[40][3:0] != 4'h0);
    q_a.push_back(e);
    n_push_a++;
    last_a = e.data;
  endtask

  task automatic push_timeout_a();
    exp_t e;
    e.is_to = 1'b1;
    e.data  = last_a;
    e.pad   = 1'b0;
    q_a.push_back(e);
    n_push_a++;
  endtask

  task automatic push_done_b();
    exp_t e;
    e.is_to = 1'b0;
    e.data  = model_vec(4);
    e.pad   = 1'b0;
    q_b.push_back(e);
    n_push_b++;
  endtask

  task automatic mon_a(input bit is_to);
    exp_t e;
    n_ev_a++;
    if (q_a.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL a_unexpected_event: got event kind %0d, want none", is_to);
    end else begin
      e = q_a.pop_front();
      chk("a_event_kind", 324'(is_to), 324'(e.is_to));
      chk("a_data_received", out_a, e.data);
      chk("a_pad_error", 324'(pad_a), 324'(e.pad));
    end
  endtask

  task automatic mon_b();
    exp_t e;
    n_ev_b++;
    if (q_b.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL b_unexpected_event: got done, want none");
    end else begin
      e = q_b.pop_front();
      chk("b_data_received", 324'(out_b), e.data);
      chk("b_pad_error", 324'(pad_b), 324'(e.pad));
    end
  endtask

  logic done_a_q = 1'b0, to_a_q = 1'b0, done_b_q = 1'b0;
  always @(negedge clk) begin
    if (done_a && !done_a_q) mon_a(1'b0);
    if (to_a && !to_a_q) mon_a(1'b1);
    if (done_b && !done_b_q) mon_b();
    done_a_q <= done_a;
    to_a_q   <= to_a;
    done_b_q <= done_b;
  end

  task automatic chk_reset_state();
    chk("rst_a_data", out_a, '0);
    chk("rst_a_done", 324'(done_a), 0);
    chk("rst_a_pad", 324'(pad_a), 0);
    chk("rst_a_timeout", 324'(to_a), 0);
    chk("rst_a_ready", 324'(ready_a), 0);
    chk("rst_b_data", 324'(out_b), 0);
    chk("rst_b_ready", 324'(ready_b), 0);
  endtask

  task automatic arm_a();
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("a_ready_after_arm", 324'(ready_a), 1);
    chk("a_done_cleared_on_arm", 324'(done_a), 0);
    chk("a_flags_cleared_on_arm", 324'({pad_a, to_a}), 0);
  endtask

  task automatic send_bytes_a(input int n, input int maxgap);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      valid_a = 1'b1;
      data_a  = fb[k];
      if (k == 40) chk("a_done_before_last_byte", 324'(done_a), 0);
      @(posedge clk);
      @(negedge clk);
      valid_a = 1'b0;
    end
  endtask

  task automatic full_frame_a(input bit hold_start);
    arm_a();
    if (!hold_start) start_a = 1'($urandom_range(0, 1));
    push_done_a();
    send_bytes_a(41, 3);
    chk("a_done_one_clock_after_last", 324'(done_a), 1);
    if (!hold_start) start_a = 1'b0;
  endtask

  task automatic random_bytes(input int n);
    for (int k = 0; k < n; k++) fb[k] = 8'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start_a = 1'b0; valid_a = 1'b0; data_a = '0;
    start_b = 1'b0; valid_b = 1'b0; data_b = '0;
    repeat (3) @(negedge clk);
    chk_reset_state();
    rst = 1'b0;

    // Counting pattern, zero pad nibble
    for (int k = 0; k < 40; k++) fb[k] = {4'(k), ~4'(k)};
    fb[40] = 8'h80;
    full_frame_a(1'b0);
    chk("t1_unit0", 324'(out_a[323:320]), 324'h0);
    chk("t1_unit1", 324'(out_a[319:316]), 324'hf);
    chk("t1_unit80", 324'(out_a[3:0]), 324'h8);

    // Nonzero pad nibble
    random_bytes(40);
    fb[40] = 8'h95;
    full_frame_a(1'b0);
    chk("t2_unit80", 324'(out_a[3:0]), 324'h9);
    chk("t2_pad_error", 324'(pad_a), 1);

    // Gap timeout after 10 bytes
    arm_a();
    start_a = 1'b0;
    random_bytes(41);
    send_bytes_a(10, 3);
    push_timeout_a();
    repeat (15) @(negedge clk);
    chk("t3_no_timeout_at_15", 324'(to_a), 0);
    @(negedge clk);
    chk("t3_timeout_at_16", 324'(to_a), 1);
    chk("t3_ready_low", 324'(ready_a), 0);
    chk("t3_data_kept", out_a, last_a);
    random_bytes(41);
    full_frame_a(1'b0);

    // Reset mid-frame
    arm_a();
    start_a = 1'b0;
    random_bytes(41);
    send_bytes_a(21, 2);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state();
    rst = 1'b0;
    last_a = '0;
    random_bytes(41);
    full_frame_a(1'b0);

    // Byte offered while idle, then start held through S_DONE
    valid_a = 1'b1;
    data_a  = 8'h5a;
    repeat (2) @(negedge clk);
    chk("t6_idle_ready_low", 324'(ready_a), 0);
    valid_a = 1'b0;
    random_bytes(41);
    full_frame_a(1'b1);
    valid_a = 1'b1;
    data_a  = 8'h3c;
    repeat (3) @(negedge clk);
    chk("t6_done_held", 324'(done_a), 1);
    chk("t6_done_ready_low", 324'(ready_a), 0);
    chk("t6_done_byte_dropped", out_a, last_a);
    valid_a = 1'b0;
    start_a = 1'b0;
    @(negedge clk);
    chk("t6_done_held_in_idle", 324'(done_a), 1);

    for (int f = 0; f < 4; f++) begin
      random_bytes(41);
      full_frame_a(1'b0);
    end

    // Even-width instance: back-to-back bytes, extra byte in S_DONE dropped
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_ready_after_arm", 324'(ready_b), 1);
    fb[0] = 8'hab;
    fb[1] = 8'hcd;
    push_done_b();
    valid_b = 1'b1;
    data_b  = 8'hab;
    @(posedge clk);
    @(negedge clk);
    data_b = 8'hcd;
    @(posedge clk);
    @(negedge clk);
    chk("t5_done", 324'(done_b), 1);
    chk("t5_data", 324'(out_b), 324'habcd);
    data_b = 8'hef;
    @(posedge clk);
    @(negedge clk);
    chk("t5_third_byte_dropped", 324'(out_b), 324'habcd);
    chk("t5_ready_low_in_done", 324'(ready_b), 0);
    valid_b = 1'b0;
    start_b = 1'b0;

    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      @(negedge clk);
      start_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_b = 1'b0;
      random_bytes(2);
      push_done_b();
      for (int k = 0; k < 2; k++) begin
        valid_b = 1'b1;
        data_b  = fb[k];
        @(posedge clk);
        @(negedge clk);
      end
      valid_b = 1'b0;
      chk("b_done_after_frame", 324'(done_b), 1);
    end

    repeat (3) @(negedge clk);
    chk("a_scoreboard_drained", 324'(q_a.size()), 0);
    chk("a_event_count", 324'(n_ev_a), 324'(n_push_a));
    chk("b_scoreboard_drained", 324'(q_b.size()), 0);
    chk("b_event_count", 324'(n_ev_b), 324'(n_push_b));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
